// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the multiplier sequencer: FSM state encoding,
// default parameter values and the wait-counter width helper.
package mult_seq_ctrl_pkg;

    localparam int W_DEFAULT           = 8;
    localparam int FIFO_DEPTH_DEFAULT  = 4;
    // Multiplier needs 9 cycles after load drops; 10 leaves one cycle of margin.
    localparam int WAIT_CYCLES_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter is wide enough to hold WAIT_CYCLES itself, so saturation never aliases.
    function automatic int cnt_width(input int wait_cycles);
        return $clog2(wait_cycles) + 1;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Bus bundle between the sequencer, its operand/result streams and the
// shift-add multiplier pins.
//
// Handshake rule for both streams (in_* and res_*): a transfer happens on a
// rising clk edge where valid and ready are both high. The producer holds
// valid and its payload unchanged until that edge; ready may be changed
// freely and has no meaning while valid is low.
interface mult_seq_ctrl_if
    import mult_seq_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_load;
    logic [2*W-1:0] mul_y;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_y;

    // Environment side: operand source, result sink and the multiplier itself.
    modport master (
        output in_valid, in_a, in_b, res_ready, mul_y,
        input  in_ready, mul_a, mul_b, mul_load, res_valid, res_y
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, res_ready, mul_y,
        output in_ready, mul_a, mul_b, mul_load, res_valid, res_y
    );

endinterface

// File: rtl/mult_op_fifo.sv
// Synchronous first-word-fall-through FIFO for operand pairs. Pointers carry
// one extra wrap bit so full and empty are told apart without a counter.
// A push while full is accepted only if a pop happens in the same cycle.
module mult_op_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 8x8 shift-add multiplier: queues operand pairs, loads
// them one at a time, waits a fixed compute window and returns the product
// on a valid/ready result stream.
// Optional build macro MULT_SEQ_ZERO_BYPASS_EN: pairs with a zero operand are
// answered with 0 without pulsing mul_load or touching mul_a/mul_b.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int W           = W_DEFAULT,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus,
    output state_t         dbg_state
);
    localparam int             CW       = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mul_a_q;
    logic [W-1:0]   mul_b_q;
    logic           mul_load_q;
    logic           res_valid_q;
    logic [2*W-1:0] res_y_q;

    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           res_ack;
    logic [2*W-1:0] head;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    logic           zero_pend;
    logic           head_zero;
    assign head_zero = (head[2*W-1:W] == '0) || (head[W-1:0] == '0);
`endif

    assign bus.in_ready  = !full && !rst;
    assign push          = bus.in_valid && bus.in_ready;
    assign res_ack       = res_valid_q && bus.res_ready;
    // Next pair is taken when idle, or straight out of DONE as the result leaves.
    assign pop           = !empty && ((state == ST_IDLE) || ((state == ST_DONE) && res_ack));

    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_load  = mul_load_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_y     = res_y_q;
    assign dbg_state     = state;

    mult_op_fifo #(
        .DW    (2 * W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.in_a, bus.in_b}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Sequencer FSM with registered multiplier pins, wait counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_load_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
            zero_pend   <= 1'b0;
`endif
        end else begin
            mul_load_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if ((state == ST_DONE) && res_ack) res_valid_q <= 1'b0;
                    if (pop) begin
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                        if (head_zero) begin
                            zero_pend <= 1'b1;
                        end else begin
                            mul_a_q    <= head[2*W-1:W];
                            mul_b_q    <= head[W-1:0];
                            mul_load_q <= 1'b1;
                        end
`else
                        mul_a_q    <= head[2*W-1:W];
                        mul_b_q    <= head[W-1:0];
                        mul_load_q <= 1'b1;
`endif
                        state <= ST_LOAD;
                    end else if ((state == ST_DONE) && res_ack) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    cnt <= '0;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                    if (zero_pend) begin
                        // Product of a zero operand is known without the multiplier.
                        zero_pend   <= 1'b0;
                        res_y_q     <= '0;
                        res_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        state <= ST_WAIT;
                    end
`else
                    state <= ST_WAIT;
`endif
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        res_y_q     <= bus.mul_y;
                        res_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl wired to a behavioural shift-add multiplier.
// Honours MULT_SEQ_ZERO_BYPASS_EN for the expected latency of zero pairs.
module tb_mult_seq_ctrl;
    import mult_seq_ctrl_pkg::*;

    localparam int LAT_MUL    = WAIT_CYCLES_DEFAULT + 2;
    localparam int LAT_BYPASS = 2;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     cyc;
    int     checks;
    int     failures;

    mult_seq_ctrl_if bus ();

    mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- multiplier model ----------------
    // One partial product per cycle for 8 cycles, then a register stage:
    // the product appears 9 cycles after load drops. A is read on every step.
    logic [15:0] m_acc;
    logic [3:0]  m_step;
    always @(posedge clk) begin
        if (rst) begin
            m_acc     <= '0;
            m_step    <= 4'd9;
            bus.mul_y <= '0;
        end else if (bus.mul_load) begin
            m_acc  <= '0;
            m_step <= 4'd0;
        end else if (m_step < 4'd8) begin
            if (bus.mul_a[m_step[2:0]]) m_acc <= m_acc + ({8'b0, bus.mul_b} << m_step);
            m_step <= m_step + 4'd1;
        end else if (m_step == 4'd8) begin
            bus.mul_y <= m_acc;
            m_step    <= 4'd9;
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
        return (a == 0 || b == 0) ? LAT_BYPASS : LAT_MUL;
`else
        return (a == 0 && b == 0 && 1'b0) ? LAT_BYPASS : LAT_MUL;
`endif
    endfunction

    function automatic int exp_loads(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
        return (a == 0 || b == 0) ? 0 : 1;
`else
        return (a == b && 1'b0) ? 0 : 1;
`endif
    endfunction

    // ---------------- scoreboard / monitor ----------------
    // Sampled at negedge: inputs and outputs are what the next posedge acts on.
    logic [15:0] exp_q[$];
    int          hs_q[$];
    int          load_cnt;
    int          res_cnt;
    logic        computing;
    logic [7:0]  a_hold;
    logic [7:0]  b_hold;
    logic        hold_valid;
    logic [15:0] hold_y;

    always @(negedge clk) begin
        if (hold_valid) begin
            check("res_valid_held", 32'(bus.res_valid), 32'd1);
            check("res_y_held", 32'(bus.res_y), 32'(hold_y));
        end
        if (computing) begin
            if (bus.res_valid) computing = 1'b0;
            else begin
                check("mul_a_stable", 32'(bus.mul_a), 32'(a_hold));
                check("mul_b_stable", 32'(bus.mul_b), 32'(b_hold));
            end
        end
        if (bus.mul_load) begin
            load_cnt++;
            computing = 1'b1;
            a_hold    = bus.mul_a;
            b_hold    = bus.mul_b;
        end
        if (rst) begin
            exp_q.delete();
            computing  = 1'b0;
            hold_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(16'(bus.in_a) * 16'(bus.in_b));
            if (bus.res_valid && bus.res_ready) begin
                res_cnt++;
                hs_q.push_back(cyc + 1);
                if (exp_q.size() == 0) check("unexpected_result", 32'(bus.res_y), 32'hFFFF_FFFF);
                else check("res_y_order", 32'(bus.res_y), 32'(exp_q.pop_front()));
            end
            hold_valid = bus.res_valid && !bus.res_ready;
            hold_y     = bus.res_y;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Offer one pair; returns the edge number at which it was accepted (-1 on timeout).
    task automatic push(input logic [7:0] a, input logic [7:0] b, output int e);
        e = -1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.in_ready && !rst) begin
                e = cyc + 1;
                break;
            end
        end
        step(1);
        bus.in_valid = 1'b0;
        if (e < 0) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Returns the edge after which res_valid was first seen high, and res_y then.
    task automatic wait_valid(output int e, output logic [15:0] y);
        e = -1;
        y = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                e = cyc;
                y = bus.res_y;
                break;
            end
        end
        step(1);
        if (e < 0) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 1000 && exp_q.size() != 0; n++) step(1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    vec_t        vecs[8];
    int          pe;
    int          ve;
    int          e5[6];
    int          l0;
    int          r0;
    int          hs0;
    int          rel;
    logic [15:0] y;
    logic [15:0] y0;
    logic [7:0]  a0;
    logic        prod_done;

    initial begin
        vecs[0] = '{a: 8'd3,   b: 8'd5,   y: 16'd15};
        vecs[1] = '{a: 8'd255, b: 8'd255, y: 16'hFE01};
        vecs[2] = '{a: 8'd0,   b: 8'd200, y: 16'd0};
        vecs[3] = '{a: 8'd7,   b: 8'd9,   y: 16'd63};
        vecs[4] = '{a: 8'd1,   b: 8'd1,   y: 16'd1};
        vecs[5] = '{a: 8'd128, b: 8'd2,   y: 16'd256};
        vecs[6] = '{a: 8'd200, b: 8'd0,   y: 16'd0};
        vecs[7] = '{a: 8'd170, b: 8'd85,  y: 16'd14450};

        cyc = 0; checks = 0; failures = 0;
        load_cnt = 0; res_cnt = 0;
        computing = 1'b0; hold_valid = 1'b0; hold_y = '0;
        a_hold = '0; b_hold = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b1;

        // Reset state
        step(2);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mul_a", 32'(bus.mul_a), 32'd0);
        check("rst_mul_b", 32'(bus.mul_b), 32'd0);
        check("rst_mul_load", 32'(bus.mul_load), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_y", 32'(bus.res_y), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step(1);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single-operation vectors (T1, T2, T6 and friends)
        for (int i = 0; i < 8; i++) begin
            l0 = load_cnt;
            push(vecs[i].a, vecs[i].b, pe);
            wait_valid(ve, y);
            check("vec_res_y", 32'(y), 32'(vecs[i].y));
            check("vec_latency", 32'(ve - pe), 32'(exp_lat(vecs[i].a, vecs[i].b)));
            step(2);
            check("vec_load_pulses", 32'(load_cnt - l0), 32'(exp_loads(vecs[i].a, vecs[i].b)));
        end

        // T3: back-to-back pushes fill the FIFO; the 6th waits for the next pop
        hs0 = hs_q.size();
        for (int i = 0; i < 5; i++) begin
            push(8'(10 + i), 8'(20 + 3 * i), e5[i]);
            if (i > 0) check("b2b_accept", 32'(e5[i] - e5[0]), 32'(i));
        end
        push(8'd99, 8'd77, e5[5]);
        check("full_stall_accept", 32'(e5[5] - e5[0]), 32'(LAT_MUL + 2));
        drain();
        check("t3_results", 32'(hs_q.size() - hs0), 32'd6);
        if (hs_q.size() - hs0 == 6) begin
            check("t3_first_hs", 32'(hs_q[hs0] - e5[0]), 32'(LAT_MUL + 1));
            for (int k = 1; k < 6; k++)
                check("t3_spacing", 32'(hs_q[hs0 + k] - hs_q[hs0 + k - 1]), 32'(LAT_MUL));
        end

        // T4: stall the result for 20 cycles
        bus.res_ready = 1'b0;
        push(8'd11, 8'd13, pe);
        push(8'd21, 8'd3, pe);
        wait_valid(ve, y0);
        check("t4_first_y", 32'(y0), 32'd143);
        l0 = load_cnt;
        a0 = bus.mul_a;
        for (int n = 0; n < 20; n++) begin
            step(1);
            check("t4_valid_hold", 32'(bus.res_valid), 32'd1);
            check("t4_y_hold", 32'(bus.res_y), 32'(y0));
            check("t4_mul_a_hold", 32'(bus.mul_a), 32'(a0));
            check("t4_no_load", 32'(load_cnt), 32'(l0));
        end
        bus.res_ready = 1'b1;
        rel = cyc + 1;
        step(1);
        wait_valid(ve, y);
        check("t4_next_y", 32'(y), 32'd63);
        check("t4_next_latency", 32'(ve - rel), 32'(LAT_MUL - 1));
        drain();

        // T5: reset in the middle of the wait window
        push(8'd3, 8'd4, pe);
        step(5);
        rst = 1'b1;
        step(1);
        check("t5_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_mul_a", 32'(bus.mul_a), 32'd0);
        check("t5_mul_b", 32'(bus.mul_b), 32'd0);
        check("t5_mul_load", 32'(bus.mul_load), 32'd0);
        check("t5_res_valid", 32'(bus.res_valid), 32'd0);
        check("t5_res_y", 32'(bus.res_y), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step(1);
        check("t5_in_ready_after", 32'(bus.in_ready), 32'd1);
        l0 = load_cnt;
        r0 = res_cnt;
        step(20);
        check("t5_no_result", 32'(res_cnt), 32'(r0));
        check("t5_no_load", 32'(load_cnt), 32'(l0));
        push(8'd7, 8'd9, pe);
        wait_valid(ve, y);
        check("t5_res_y", 32'(y), 32'd63);
        check("t5_latency", 32'(ve - pe), 32'(LAT_MUL));
        drain();

        // Randomized traffic with random backpressure
        r0 = res_cnt;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    step($urandom_range(0, 3));
                    push(($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                         ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)), pe);
                end
                prod_done = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !(prod_done && exp_q.size() == 0); n++) begin
                    step(1);
                    bus.res_ready = ($urandom_range(0, 3) != 0);
                end
                bus.res_ready = 1'b1;
            end
        join
        drain();
        check("rand_result_count", 32'(res_cnt - r0), 32'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
